pipe_stage_latch: RTL and testbench

- Pipeline register between two CPU stages. It is the consuming end of the per-latch pipe-state command (ENABLE/STALL/NOP) that the hazard unit drives.
- It holds the stage payload and reports the stage's destination register back to the hazard unit, which compares it against rs/rt as ex_wsel/mem_wsel.
- One instance sits at each of the fetch/decode, decode/execute, execute/memory and memory/writeback boundaries. It also tracks bubble/hold status and stall duration.

---
 rtl/pipe_stage_latch_if.sv | 32 +++
 rtl/pipe_stage_latch.sv | 112 +++++++++++
 tb/tb_pipe_stage_latch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_latch_if.sv
// Stage-latch bus: command and incoming stage fields from the hazard unit and the
// upstream stage, registered stage fields and status back to the hazard unit.
interface pipe_stage_latch_if #(
  parameter int PW = 64,
  parameter int CW = 8
);
  logic [1:0]    pipe_state;
  logic [PW-1:0] payload_i;
  logic          valid_i;
  logic          regwen_i;
  logic [4:0]    wsel_i;
  logic [PW-1:0] payload_o;
  logic          valid_o;
  logic          regwen_o;
  logic [4:0]    wsel_o;
  logic [1:0]    stage_st;
  logic [CW-1:0] stall_cnt;
  logic          stall_timeout;
  logic          illegal_cmd;

  modport master (
    output pipe_state, payload_i, valid_i, regwen_i, wsel_i,
    input  payload_o, valid_o, regwen_o, wsel_o, stage_st, stall_cnt,
           stall_timeout, illegal_cmd
  );

  modport slave (
    input  pipe_state, payload_i, valid_i, regwen_i, wsel_i,
    output payload_o, valid_o, regwen_o, wsel_o, stage_st, stall_cnt,
           stall_timeout, illegal_cmd
  );
endinterface

// File: rtl/pipe_stage_latch.sv
// Pipeline register between two CPU stages, driven by the ENABLE/STALL/NOP command.
// Optional per-command cycle counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_latch #(
  parameter int PW      = 64,
  parameter int CW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic CLK,
  input  logic RST,
  pipe_stage_latch_if.slave bus
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0] en_count,
  output logic [31:0] stall_count,
  output logic [31:0] nop_count
`endif
);
  // state | meaning
  // RUN    | a real instruction was loaded on the last ENABLE
  // HOLD   | a real instruction is being held by STALL
  // BUBBLE | no real instruction present (reset, NOP, illegal, ENABLE of a bubble)
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } stage_t;

  localparam logic [1:0]    CMD_ENABLE = 2'd0;
  localparam logic [1:0]    CMD_STALL  = 2'd1;
  localparam logic [1:0]    CMD_ILL    = 2'd3;
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] TO_VAL     = CW'(TIMEOUT);

  stage_t        state;
  logic [PW-1:0] payload_q;
  logic          valid_q;
  logic          regwen_q;
  logic [4:0]    wsel_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          to_q;
  logic          ill_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_BUBBLE;
      payload_q <= '0;
      valid_q   <= 1'b0;
      regwen_q  <= 1'b0;
      wsel_q    <= 5'd0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      case (bus.pipe_state)
        CMD_ENABLE: begin
          payload_q <= bus.payload_i;
          valid_q   <= bus.valid_i;
          regwen_q  <= bus.regwen_i & bus.valid_i;
          wsel_q    <= bus.wsel_i;
          state     <= bus.valid_i ? ST_RUN : ST_BUBBLE;
          cnt_q     <= '0;
          to_q      <= 1'b0;
        end
        CMD_STALL: begin
          state <= (state == ST_BUBBLE && !valid_q) ? ST_BUBBLE : ST_HOLD;
          cnt_q <= cnt_inc;
          to_q  <= (cnt_inc >= TO_VAL);
        end
        default: begin
          // illegal encoding squashes the stage exactly like NOP
          payload_q <= '0;
          valid_q   <= 1'b0;
          regwen_q  <= 1'b0;
          wsel_q    <= 5'd0;
          state     <= ST_BUBBLE;
          cnt_q     <= '0;
          to_q      <= 1'b0;
          if (bus.pipe_state == CMD_ILL) ill_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.payload_o     = payload_q;
  assign bus.valid_o       = valid_q;
  assign bus.regwen_o      = regwen_q;
  // never present a nonzero destination for a bubble or non-writing instruction
  assign bus.wsel_o        = (valid_q & regwen_q) ? wsel_q : 5'd0;
  assign bus.stage_st      = state;
  assign bus.stall_cnt     = cnt_q;
  assign bus.stall_timeout = to_q;
  assign bus.illegal_cmd   = ill_q;

`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_count    <= 32'd0;
      stall_count <= 32'd0;
      nop_count   <= 32'd0;
    end else begin
      case (bus.pipe_state)
        CMD_ENABLE: if (en_count != 32'hFFFF_FFFF) en_count <= en_count + 32'd1;
        CMD_STALL:  if (stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
        default:    if (nop_count != 32'hFFFF_FFFF) nop_count <= nop_count + 32'd1;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_latch.sv
// Randomized and directed bench for pipe_stage_latch against a behavioural model.
module tb_pipe_stage_latch;
  localparam int PW = 64;
  localparam int CW = 4;
  localparam int TIMEOUT = 10;
  localparam int CMAX = 15;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pipe_stage_latch_if #(.PW(PW), .CW(CW)) bus();

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] en_count, stall_count, nop_count;
`endif

  pipe_stage_latch #(.PW(PW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .en_count(en_count),
    .stall_count(stall_count),
    .nop_count(nop_count)
`endif
  );

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // behavioural model
  logic [PW-1:0] m_payload;
  bit            m_valid, m_regwen, m_to, m_ill;
  logic [4:0]    m_wsel;
  int            m_cnt, m_st;
  longint        m_en, m_stall, m_nop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_payload = '0; m_valid = 0; m_regwen = 0; m_wsel = 0;
    m_cnt = 0; m_to = 0; m_ill = 0; m_st = 2;
    m_en = 0; m_stall = 0; m_nop = 0;
  endfunction

  function automatic void m_apply(input logic [1:0] cmd, input logic [PW-1:0] pl,
                                  input bit v, input bit rw, input logic [4:0] ws);
    if (cmd == 2'd0) begin
      m_payload = pl; m_valid = v; m_regwen = rw && v; m_wsel = ws;
      m_st = v ? 0 : 2; m_cnt = 0; m_to = 0; m_en++;
    end else if (cmd == 2'd1) begin
      m_st = m_valid ? 1 : 2;
      m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      m_to = (m_cnt >= TIMEOUT); m_stall++;
    end else begin
      m_payload = '0; m_valid = 0; m_regwen = 0;
      m_st = 2; m_cnt = 0; m_to = 0; m_nop++;
      if (cmd == 2'd3) m_ill = 1;
    end
  endfunction

  task automatic compare_all();
    chk("payload_o", bus.payload_o, m_payload);
    chk("valid_o", 64'(bus.valid_o), 64'(m_valid));
    chk("regwen_o", 64'(bus.regwen_o), 64'(m_regwen));
    chk("wsel_o", 64'(bus.wsel_o), (m_valid && m_regwen) ? 64'(m_wsel) : 64'd0);
    chk("stage_st", 64'(bus.stage_st), 64'(m_st));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    chk("stall_timeout", 64'(bus.stall_timeout), 64'(m_to));
    chk("illegal_cmd", 64'(bus.illegal_cmd), 64'(m_ill));
`ifdef PIPE_STAGE_STATS_EN
    chk("en_count", 64'(en_count), 64'(m_en));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
    chk("nop_count", 64'(nop_count), 64'(m_nop));
`endif
  endtask

  always @(negedge CLK) if (chk_on) compare_all();

  task automatic step(input logic [1:0] cmd, input logic [PW-1:0] pl,
                      input bit v, input bit rw, input logic [4:0] ws);
    bus.pipe_state = cmd; bus.payload_i = pl; bus.valid_i = v;
    bus.regwen_i = rw; bus.wsel_i = ws;
    @(posedge CLK);
    if (!RST) m_apply(cmd, pl, v, rw, ws);
    @(negedge CLK);
  endtask

  task automatic async_reset();
    #2 RST = 1'b1;
    m_reset();
    #1;
    chk("rst_payload", bus.payload_o, 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_wsel", 64'(bus.wsel_o), 64'd0);
    chk("rst_stage", 64'(bus.stage_st), 64'd2);
    chk("rst_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_ill", 64'(bus.illegal_cmd), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    logic [1:0] cmd;
    int r;
    RST = 1'b1;
    bus.pipe_state = 2'd0; bus.payload_i = '0; bus.valid_i = 0;
    bus.regwen_i = 0; bus.wsel_i = 0;
    m_reset();
    #3;
    chk("por_stage", 64'(bus.stage_st), 64'd2);
    chk("por_valid", 64'(bus.valid_o), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    chk_on = 1'b1;

    // stall from reset stays a bubble
    step(2'd1, '0, 0, 0, 0);
    chk("bubble_stall_stage", 64'(bus.stage_st), 64'd2);

    step(2'd0, 64'hDEAD_BEEF, 1, 1, 5'd5);
    chk("en_payload", bus.payload_o, 64'hDEAD_BEEF);
    chk("en_wsel", 64'(bus.wsel_o), 64'd5);
    chk("en_stage", 64'(bus.stage_st), 64'd0);
    for (int i = 0; i < 3; i++) step(2'd1, 64'h1234, 0, 0, 5'd7);
    chk("hold_payload", bus.payload_o, 64'hDEAD_BEEF);
    chk("hold_cnt", 64'(bus.stall_cnt), 64'd3);
    chk("hold_stage", 64'(bus.stage_st), 64'd1);
    chk("hold_wsel", 64'(bus.wsel_o), 64'd5);
    step(2'd2, 64'h55, 1, 1, 5'd3);
    chk("nop_valid", 64'(bus.valid_o), 64'd0);
    chk("nop_wsel", 64'(bus.wsel_o), 64'd0);
    chk("nop_payload", bus.payload_o, 64'd0);
    chk("nop_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("nop_stage", 64'(bus.stage_st), 64'd2);

    step(2'd0, 64'hABCD, 1, 0, 5'd9);
    chk("nowr_wsel", 64'(bus.wsel_o), 64'd0);
    chk("nowr_regwen", 64'(bus.regwen_o), 64'd0);
    chk("nowr_stage", 64'(bus.stage_st), 64'd0);

    // ENABLE of a bubble keeps the payload
    step(2'd0, 64'hF00D, 0, 1, 5'd4);
    chk("enbub_payload", bus.payload_o, 64'hF00D);
    chk("enbub_regwen", 64'(bus.regwen_o), 64'd0);
    chk("enbub_stage", 64'(bus.stage_st), 64'd2);

    step(2'd0, 64'h77, 1, 1, 5'd12);
    for (int i = 1; i <= 20; i++) begin
      step(2'd1, '0, 0, 0, 0);
      if (i == 9)  chk("to_edge9", 64'(bus.stall_timeout), 64'd0);
      if (i == 10) chk("to_edge10", 64'(bus.stall_timeout), 64'd1);
      if (i == 10) chk("cnt_edge10", 64'(bus.stall_cnt), 64'd10);
    end
    chk("cnt_sat", 64'(bus.stall_cnt), 64'd15);
    chk("to_sat", 64'(bus.stall_timeout), 64'd1);
    step(2'd0, 64'h88, 1, 1, 5'd1);
    chk("to_clear_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("to_clear", 64'(bus.stall_timeout), 64'd0);

    // reset in the middle of a stall
    step(2'd1, '0, 0, 0, 0);
    step(2'd1, '0, 0, 0, 0);
    bus.pipe_state = 2'd0; bus.payload_i = 64'h99; bus.valid_i = 1;
    bus.regwen_i = 1; bus.wsel_i = 5'd6;
    async_reset();
    step(2'd0, 64'h99, 1, 1, 5'd6);
    chk("post_rst_payload", bus.payload_o, 64'h99);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      cmd = (r < 7) ? 2'd0 : (r < 16) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
      if (n < 150 && cmd == 2'd3) cmd = 2'd2;
      step(cmd, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
           1'($urandom), 5'($urandom));
    end

    step(2'd0, 64'h1111, 1, 1, 5'd2);
    step(2'd3, 64'h2222, 1, 1, 5'd3);
    chk("ill_valid", 64'(bus.valid_o), 64'd0);
    chk("ill_flag", 64'(bus.illegal_cmd), 64'd1);
    chk("ill_stage", 64'(bus.stage_st), 64'd2);
    for (int i = 0; i < 3; i++) step(2'd0, 64'h3333, 1, 1, 5'd8);
    chk("ill_sticky", 64'(bus.illegal_cmd), 64'd1);
    async_reset();
    chk("ill_cleared", 64'(bus.illegal_cmd), 64'd0);
    step(2'd2, '0, 0, 0, 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
